// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the input SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_DEPTH     = 1024;
  localparam int unsigned DEF_RSP_DEPTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

endpackage

// File: rtl/input_sram_ctrl_if.sv
// Request/response bus between a requester (master) and the SRAM controller (slave).
interface input_sram_ctrl_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 1024
) ();
  localparam int unsigned ADDR_W = $clog2(DEPTH * LANES);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic                      req_line;
  logic [ADDR_W-1:0]         req_addr;
  logic [WORD_W/8-1:0]       req_wstrb;
  logic [WORD_W-1:0]         req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [WORD_W*LANES-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_line, req_addr, req_wstrb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_line, req_addr, req_wstrb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// Read-response queue; rdata shows the head entry and reads as zero when empty.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RSTn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/input_sram_ctrl.sv
// Front end for a single-port line-wide SRAM macro: lane/line reads, full-word writes,
// partial writes via read-modify-write. Define SRAM_PERF_CNT_EN to add rd_cnt/wr_cnt.
module input_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH,
  localparam int unsigned LA_W     = $clog2(DEPTH),
  localparam int unsigned ADDR_W   = $clog2(DEPTH * LANES)
) (
  input  logic                    CK,
  input  logic                    RSTn,
  input_sram_ctrl_if.slave        bus,
  output logic                    sram_cs,
  output logic                    sram_oe,
  output logic [LANES-1:0]        sram_web,
  output logic [LA_W-1:0]         sram_a,
  output logic [WORD_W*LANES-1:0] sram_di,
  input  logic [WORD_W*LANES-1:0] sram_do
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt
`endif
);
  localparam int unsigned SEL_W  = $clog2(LANES);
  localparam int unsigned STRB_W = WORD_W / 8;
  localparam int unsigned LINE_W = WORD_W * LANES;
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

  state_e              state_q;
  logic                out_en_q, rd_pend_q, rd_line_q;
  logic [SEL_W-1:0]    rd_lane_q, rmw_lane_q;
  logic [LA_W-1:0]     rmw_a_q;
  logic [STRB_W-1:0]   rmw_strb_q;
  logic [WORD_W-1:0]   rmw_wdata_q;

  logic                accept, is_rd, is_full_wr, is_rmw;
  logic [SEL_W-1:0]    lane;
  logic [LA_W-1:0]     line_a;
  logic [WORD_W-1:0]   rd_word, rmw_old, rmw_word;
  logic [LINE_W-1:0]   push_data;
  logic                fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]    fifo_count;

  assign lane   = bus.req_addr[SEL_W-1:0];
  assign line_a = bus.req_addr[ADDR_W-1:SEL_W];

  // A read in flight has already reserved its FIFO slot.
  assign bus.req_ready = out_en_q && (state_q == IDLE) && !fifo_full &&
                         (32'(fifo_count) + 32'(rd_pend_q) < RSP_DEPTH);
  assign accept     = bus.req_valid && bus.req_ready;
  assign is_rd      = accept && !bus.req_we;
  assign is_full_wr = accept && bus.req_we && (&bus.req_wstrb);
  assign is_rmw     = accept && bus.req_we && (|bus.req_wstrb) && !(&bus.req_wstrb);

  assign rd_word = sram_do[rd_lane_q*WORD_W +: WORD_W];
  assign rmw_old = sram_do[rmw_lane_q*WORD_W +: WORD_W];

  always_comb begin
    rmw_word = rmw_old;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (rmw_strb_q[b]) rmw_word[8*b +: 8] = rmw_wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    push_data = '0;
    push_data[WORD_W-1:0] = rd_word;
    if (rd_line_q) push_data = sram_do;
  end

  // Macro controls are combinational so the macro samples in the accept cycle itself.
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = '1;
    sram_a   = line_a;
    sram_di  = {LANES{bus.req_wdata}};
    if (state_q == RMW) begin
      sram_cs             = 1'b1;
      sram_web[rmw_lane_q] = 1'b0;
      sram_a              = rmw_a_q;
      sram_di             = {LANES{rmw_word}};
    end else if (is_rd || is_rmw) begin
      sram_cs = 1'b1;
      sram_oe = 1'b1;
    end else if (is_full_wr) begin
      sram_cs        = 1'b1;
      sram_web[lane] = 1'b0;
    end
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      out_en_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_line_q   <= 1'b0;
      rd_lane_q   <= '0;
      rmw_lane_q  <= '0;
      rmw_a_q     <= '0;
      rmw_strb_q  <= '0;
      rmw_wdata_q <= '0;
    end else begin
      out_en_q  <= 1'b1;
      rd_pend_q <= is_rd;
      if (is_rd) begin
        rd_line_q <= bus.req_line;
        rd_lane_q <= lane;
      end
      unique case (state_q)
        IDLE: begin
          if (is_rmw) begin
            state_q     <= RMW;
            rmw_lane_q  <= lane;
            rmw_a_q     <= line_a;
            rmw_strb_q  <= bus.req_wstrb;
            rmw_wdata_q <= bus.req_wdata;
          end
        end
        RMW:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = !fifo_empty;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  sram_rsp_fifo #(
    .WIDTH(LINE_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .CK   (CK),
    .RSTn (RSTn),
    .push (rd_pend_q),
    .wdata(push_data),
    .pop  (pop),
    .rdata(bus.rsp_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (is_rd && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (accept && bus.req_we && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif
endmodule

// File: doc/input_sram_ctrl.md
INPUT_SRAM_CTRL -- requirements
Module: input_sram_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter LANES, default 4: words per SRAM line.
REQ-003 SHALL have parameter DEPTH, default 1024: lines in the macro.
REQ-004 SHALL have parameter RSP_DEPTH, default 3: response FIFO entries, minimum 2.
REQ-005 SHALL derive localparams LA_W = clog2(DEPTH) and ADDR_W = clog2(DEPTH*LANES).
REQ-006 SHALL have ports, listed as name, direction, width, meaning:
- CK  in  1  clock; one clock domain, all logic on posedge CK
- RSTn  in  1  reset, asynchronous, active-low
- req_valid/req_ready  in/out  1/1  request handshake
- req_we  in  1  1 = write, 0 = read
- req_line  in  1  read the full line (read only)
- req_addr  in  ADDR_W  word address; low clog2(LANES) bits select the lane
- req_wstrb  in  WORD_W/8  byte strobes
- req_wdata  in  WORD_W  write data
- rsp_valid/rsp_ready  out/in  1/1  read-response handshake
- rsp_rdata  out  WORD_W*LANES  lane word in bits [WORD_W-1:0], or the full line
- sram_cs, sram_oe  out  1  macro enables
- sram_web  out  LANES  per-lane write enable, active-low
- sram_a  out  LA_W  macro line address
- sram_di/sram_do  out/in  WORD_W*LANES  macro data

Function
REQ-007 SHALL accept a request only in the cycle where req_valid and req_ready are both 1.
REQ-008 SHALL drive req_ready = (state==IDLE) && (fifo_count + inflight < RSP_DEPTH).
REQ-009 SHALL drive, for a read accepted at cycle T: sram_cs=1, sram_oe=1, sram_web all 1 at T; capture sram_do into the FIFO at the end of T+1; rsp_valid no earlier than T+2.
REQ-010 SHALL return, for a lane read, the selected lane zero-extended into rsp_rdata; for req_line=1, the whole line with lane 0 in the LSBs.
REQ-011 SHALL sustain one read per cycle when rsp_ready is held at 1, and return responses strictly in order.
REQ-012 SHALL perform a write with all strobes set in one cycle: only the selected lane's sram_web is 0, and req_wdata is replicated across sram_di.
REQ-013 SHALL run a read-modify-write for a write with partial (nonzero) strobes:
- T: issue a lane read, FSM IDLE->RMW
- T+1: merge sram_do bytes with req_wdata under the registered strobe, write the lane, RMW->IDLE
- req_ready SHALL be 0 during T+1
REQ-014 SHALL treat a write with all-zero strobes as a no-op: accepted, no macro access.
REQ-015 SHALL ignore req_line on writes.
REQ-016 SHALL have FSM states exactly IDLE and RMW; no other transitions.
REQ-017 SHALL hold rsp_valid/rsp_rdata stable while rsp_valid=1 and rsp_ready=0; a full FIFO deasserts req_ready and never drops data.
REQ-018 SHALL allow a FIFO push and pop in the same cycle, leaving the count unchanged.
REQ-019 SHALL return post-write data for a read accepted in the cycle after a write or RMW completes to the same line.

Reset
REQ-020 SHALL, while RSTn=0: FSM=IDLE, FIFO empty, inflight=0, rsp_valid=0, req_ready=0, sram_cs=0, sram_oe=0, sram_web all 1, rsp_rdata=0, counters=0.
REQ-021 SHALL abort a read-modify-write on reset mid-operation, with no macro write issued.
REQ-022 SHALL raise req_ready in the first cycle after RSTn is released.

Configuration
REQ-023 SHALL, when SRAM_PERF_CNT_EN is defined, add outputs rd_cnt[31:0] and wr_cnt[31:0]:
- saturating counts of accepted reads and accepted writes
- a read-modify-write counts once, in wr_cnt
REQ-024 SHALL, when SRAM_PERF_CNT_EN is undefined, omit these ports and counters entirely.

Structure
REQ-025 SHALL place the state enum (IDLE, RMW) and the default WORD_W/LANES/DEPTH constants in package sram_ctrl_pkg.
REQ-026 SHALL implement the response queue as sub-module sram_rsp_fifo (width, depth parameters; push/pop/full/empty/count).

Verification
REQ-027 SHALL cover a full-strobe write:
- wr addr 0x005, data 0xDEADBEEF, strb 0xF
- expect sram_web=4'b1101, sram_a=1
- then rd 0x005 -> rsp_rdata[31:0]=0xDEADBEEF
REQ-028 SHALL cover a partial write via read-modify-write:
- init word 0x11223344
- wr strb 0x2, data 0x0000AA00
- expect req_ready=0 for one cycle
- rd -> 0x1122AA44
REQ-029 SHALL cover a line read: lanes 0..3 hold 0xA0..0xA3 at line 7; req_line=1, addr 0x01C -> rsp_rdata={0xA3,0xA2,0xA1,0xA0}.
REQ-030 SHALL cover backpressure:
- 5 back-to-back reads with rsp_ready=0
- expect req_ready low after 3 accepts
- release rsp_ready -> all 5 responses in order, none lost
REQ-031 SHALL cover reset mid-operation: RSTn low during the RMW cycle -> no sram_web=0 pulse; memory unchanged; rsp_valid=0.
REQ-032 SHALL cover, with SRAM_PERF_CNT_EN: 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2.
